fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 107 ++++++++++
 tb/tb_fetch_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch stage controller: boot delay, sequential fetch, stall hold,
// branch redirect and squash, with a registered IF/ID latch and fetch counter.
module fetch_ctrl #(
  parameter logic [7:0]  PC_RESET    = 8'h00,
  parameter logic [31:0] NOP         = 32'h0000_0013,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  input  logic        flush,
  input  logic [31:0] instruction,
  output logic [7:0]  pc,
  output logic [31:0] if_id,
  output logic        if_valid,
  output logic        boot_done,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;

  localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  boot_cnt, boot_cnt_nxt;
  logic [7:0]  pc_nxt;
  logic [31:0] if_id_nxt;
  logic        if_valid_nxt, boot_done_nxt;
  logic [15:0] fetch_count_nxt;

  always_ff @(posedge clk) begin
    if (res) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = BOOT;
    case (state)
      BOOT:      state_nxt = (boot_cnt == 4'd0) ? RUN : BOOT;
      RUN, STALL: begin
        if (br_taken || flush) state_nxt = RUN;
        else if (stall)        state_nxt = STALL;
        else                   state_nxt = RUN;
      end
      default:   state_nxt = BOOT;
    endcase
  end

  // RUN and STALL share datapath behaviour; STALL only records that we are holding.
  always_comb begin
    pc_nxt          = pc;
    if_id_nxt       = if_id;
    if_valid_nxt    = if_valid;
    boot_done_nxt   = boot_done;
    fetch_count_nxt = fetch_count;
    boot_cnt_nxt    = boot_cnt;
    case (state)
      BOOT: begin
        if_id_nxt    = NOP;
        if_valid_nxt = 1'b0;
        if (boot_cnt == 4'd0) boot_done_nxt = 1'b1;
        else                  boot_cnt_nxt  = boot_cnt - 4'd1;
      end
      RUN, STALL: begin
        if (br_taken) begin
          pc_nxt       = br_target;
          if_id_nxt    = NOP;
          if_valid_nxt = 1'b0;
        end else if (flush) begin
          if_id_nxt    = NOP;
          if_valid_nxt = 1'b0;
        end else if (!stall) begin
          pc_nxt          = pc + 8'd1;
          if_id_nxt       = instruction;
          if_valid_nxt    = 1'b1;
          fetch_count_nxt = fetch_count + 16'd1;
        end
      end
      default: begin
        if_id_nxt    = NOP;
        if_valid_nxt = 1'b0;
        boot_cnt_nxt = BOOT_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      pc          <= PC_RESET;
      if_id       <= NOP;
      if_valid    <= 1'b0;
      boot_done   <= 1'b0;
      fetch_count <= 16'd0;
      boot_cnt    <= BOOT_LOAD;
    end else begin
      pc          <= pc_nxt;
      if_id       <= if_id_nxt;
      if_valid    <= if_valid_nxt;
      boot_done   <= boot_done_nxt;
      fetch_count <= fetch_count_nxt;
      boot_cnt    <= boot_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver queues the expected post-edge state
// for each cycle it drives; the monitor pops and compares one entry per clock.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        res, stall, br_taken, flush;
  logic [7:0]  br_target;
  logic [31:0] instruction;
  logic [7:0]  pc;
  logic [31:0] if_id;
  logic        if_valid, boot_done;
  logic [15:0] fetch_count;

  typedef struct {
    int          id;
    logic [7:0]  pc;
    logic [31:0] if_id;
    logic        v;
    logic        bd;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_ctrl dut (
    .clk(clk), .res(res), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .flush(flush), .instruction(instruction),
    .pc(pc), .if_id(if_id), .if_valid(if_valid), .boot_done(boot_done),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word at address a holds 32'hA0 + a.
  assign instruction = 32'hA0 + {24'h0, pc};

  task automatic step(input logic r, input logic s, input logic b, input logic [7:0] t,
                      input logic f, input logic [7:0] epc, input logic [31:0] eir,
                      input logic ev, input logic ebd, input logic [15:0] ecnt);
    exp_t e;
    @(negedge clk);
    res = r; stall = s; br_taken = b; br_target = t; flush = f;
    e.id = vec; e.pc = epc; e.if_id = eir; e.v = ev; e.bd = ebd; e.cnt = ecnt;
    q.push_back(e);
    vec++;
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit after it.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total += 5;
      if (pc !== e.pc) begin
        bad++; $display("FAIL v%0d pc got=%h want=%h", e.id, pc, e.pc);
      end
      if (if_id !== e.if_id) begin
        bad++; $display("FAIL v%0d if_id got=%h want=%h", e.id, if_id, e.if_id);
      end
      if (if_valid !== e.v) begin
        bad++; $display("FAIL v%0d if_valid got=%b want=%b", e.id, if_valid, e.v);
      end
      if (boot_done !== e.bd) begin
        bad++; $display("FAIL v%0d boot_done got=%b want=%b", e.id, boot_done, e.bd);
      end
      if (fetch_count !== e.cnt) begin
        bad++; $display("FAIL v%0d fetch_count got=%h want=%h", e.id, fetch_count, e.cnt);
      end
    end
  end

  initial begin
    int guard;
    res = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 8'h00; flush = 1'b0;
    //    res s  b  tgt    f   pc     if_id         v  bd cnt
    step(1, 0, 0, 8'h00, 0, 8'h00, NOP,          0, 0, 16'd0);  // reset
    step(0, 0, 0, 8'h00, 0, 8'h00, NOP,          0, 0, 16'd0);  // boot 1
    step(0, 0, 0, 8'h00, 0, 8'h00, NOP,          0, 1, 16'd0);  // boot 2 -> RUN
    step(0, 0, 0, 8'h00, 0, 8'h01, 32'hA0,       1, 1, 16'd1);
    step(0, 0, 0, 8'h00, 0, 8'h02, 32'hA1,       1, 1, 16'd2);
    step(0, 0, 0, 8'h00, 0, 8'h03, 32'hA2,       1, 1, 16'd3);
    step(0, 0, 0, 8'h00, 0, 8'h04, 32'hA3,       1, 1, 16'd4);
    step(0, 0, 0, 8'h00, 0, 8'h05, 32'hA4,       1, 1, 16'd5);
    step(0, 1, 0, 8'h00, 0, 8'h05, 32'hA4,       1, 1, 16'd5);  // stall x3
    step(0, 1, 0, 8'h00, 0, 8'h05, 32'hA4,       1, 1, 16'd5);
    step(0, 1, 0, 8'h00, 0, 8'h05, 32'hA4,       1, 1, 16'd5);
    step(0, 0, 0, 8'h00, 0, 8'h06, 32'hA5,       1, 1, 16'd6);  // release
    step(0, 1, 1, 8'h40, 0, 8'h40, NOP,          0, 1, 16'd6);  // br over stall
    step(0, 0, 0, 8'h00, 0, 8'h41, 32'hE0,       1, 1, 16'd7);
    step(0, 0, 1, 8'h10, 0, 8'h10, NOP,          0, 1, 16'd7);  // br to 10
    step(0, 0, 0, 8'h00, 1, 8'h10, NOP,          0, 1, 16'd7);  // flush at pc 10
    step(0, 0, 0, 8'h00, 0, 8'h11, 32'hB0,       1, 1, 16'd8);
    step(0, 1, 0, 8'h00, 1, 8'h11, NOP,          0, 1, 16'd8);  // flush beats stall
    step(0, 1, 0, 8'h00, 0, 8'h11, NOP,          0, 1, 16'd8);  // into STALL
    step(0, 1, 1, 8'hFE, 0, 8'hFE, NOP,          0, 1, 16'd8);  // br from STALL
    step(0, 0, 0, 8'h00, 0, 8'hFF, 32'h19E,      1, 1, 16'd9);
    step(0, 0, 0, 8'h00, 0, 8'h00, 32'h19F,      1, 1, 16'd10); // pc wrap
    step(0, 0, 0, 8'h00, 0, 8'h01, 32'hA0,       1, 1, 16'd11);
    step(0, 0, 1, 8'h20, 1, 8'h20, NOP,          0, 1, 16'd11); // br beats flush
    step(0, 1, 0, 8'h00, 0, 8'h20, NOP,          0, 1, 16'd11);
    step(0, 1, 0, 8'h00, 0, 8'h20, NOP,          0, 1, 16'd11);
    step(1, 1, 0, 8'h00, 0, 8'h00, NOP,          0, 0, 16'd0);  // reset mid-stall
    step(0, 0, 1, 8'h55, 0, 8'h00, NOP,          0, 0, 16'd0);  // br ignored in BOOT
    step(1, 0, 1, 8'h55, 0, 8'h00, NOP,          0, 0, 16'd0);  // reset + br in BOOT
    step(0, 1, 1, 8'h55, 1, 8'h00, NOP,          0, 0, 16'd0);
    step(0, 0, 1, 8'h55, 0, 8'h00, NOP,          0, 1, 16'd0);
    step(0, 0, 0, 8'h00, 0, 8'h01, 32'hA0,       1, 1, 16'd1);
    // Free run until fetch_count wraps; pc tracks fetch_count[7:0] from here on.
    for (int i = 2; i <= 65537; i++) begin
      logic [15:0] c;
      logic [7:0]  p;
      c = 16'(i);
      p = c[7:0];
      step(0, 0, 0, 8'h00, 0, p, 32'hA0 + {24'h0, 8'(p - 8'd1)}, 1, 1, c);
    end
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
